// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce bank.
// Width function used by the tick divider and the per-channel filter counter.
package debounce_pkg;

    function automatic int clog2m1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser plus tick-gated
// stability filter with registered rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = 4,
    parameter bit INIT         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2m1(STABLE_COUNT);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_COUNT - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Bring the raw pin into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= INIT;
            s2 <= INIT;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Accept a new level only after it persists for STABLE_COUNT ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= INIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (s2 == dout) begin
                    cnt <= '0;
                end else if (cnt == CMAX) begin
                    cnt  <= '0;
                    dout <= s2;
                    rise <= s2;
                    fall <= ~s2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: one shared sample-tick divider feeding
// an independent filter per input channel.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int CLK_DIV      = 100,
    parameter int STABLE_COUNT = 4,
    parameter bit INIT         = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int DW = clog2m1(CLK_DIV);
    localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // Free-running divider; tick is registered so it is a clean strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (div == DMAX);
            div  <= (div == DMAX) ? '0 : div + DW'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_COUNT (STABLE_COUNT),
            .INIT         (INIT)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[i]),
            .tick  (tick),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: a slow-tick instance (DIV=4, N=3)
// and a pass-through instance (DIV=1, N=1, INIT=1).
module tb_debounce_bank;

    typedef struct {
        logic [1:0] din;
        logic [1:0] dout;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       tick;
    } vec_t;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [1:0] din_a;
    logic [1:0] din_b;
    logic [1:0] dout_a, rise_a, fall_a;
    logic [1:0] dout_b, rise_b, fall_b;
    logic       tick_a, tick_b;

    int vecs;
    int errs;

    vec_t tbl[28];

    debounce_bank #(
        .CHANNELS     (2),
        .CLK_DIV      (4),
        .STABLE_COUNT (3),
        .INIT         (1'b0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .din   (din_a),
        .dout  (dout_a),
        .rise  (rise_a),
        .fall  (fall_a),
        .tick  (tick_a)
    );

    debounce_bank #(
        .CHANNELS     (2),
        .CLK_DIV      (1),
        .STABLE_COUNT (1),
        .INIT         (1'b1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .din   (din_b),
        .dout  (dout_b),
        .rise  (rise_b),
        .fall  (fall_b),
        .tick  (tick_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] pat[15];
        logic [1:0] exp_d;
        logic [1:0] prev_d;
        int r1, f1, p0, rn, nf;
        bit got;

        vecs = 0;
        errs = 0;

        // glitch on ch0 (6 cycles high), then a clean step on ch0
        for (int i = 0; i < 28; i++) begin
            tbl[i].din  = ((i >= 4 && i <= 9) || i >= 12) ? 2'b01 : 2'b00;
            tbl[i].dout = (i >= 24) ? 2'b01 : 2'b00;
            tbl[i].rise = (i == 24) ? 2'b01 : 2'b00;
            tbl[i].fall = 2'b00;
            tbl[i].tick = (((i + 1) % 4) == 0);
        end

        pat = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01,
                2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};

        rst_a = 1'b0;
        rst_b = 1'b0;
        din_a = 2'b11;
        din_b = 2'b11;

        repeat (3) @(negedge clk);
        chk("rst_a_dout", dout_a, 2'b00);
        chk("rst_a_rise", rise_a, 2'b00);
        chk("rst_a_fall", fall_a, 2'b00);
        chk("rst_a_tick", tick_a, 0);
        chk("rst_b_dout", dout_b, 2'b11);
        chk("rst_b_pulse", {rise_b, fall_b}, 0);
        chk("rst_b_tick", tick_b, 0);

        rst_a = 1'b1;
        for (int i = 0; i < 28; i++) begin
            din_a = tbl[i].din;
            step();
            chk($sformatf("tbl%0d_dout", i), dout_a, tbl[i].dout);
            chk($sformatf("tbl%0d_rise", i), rise_a, tbl[i].rise);
            chk($sformatf("tbl%0d_fall", i), fall_a, tbl[i].fall);
            chk($sformatf("tbl%0d_tick", i), tick_a, tbl[i].tick);
        end

        // bounce on ch1, phased so the last sampled bounce value is 0
        repeat (2) begin
            din_a = 2'b01;
            step();
        end
        r1 = 0; f1 = 0; p0 = 0; rn = 0;
        for (int k = 0; k < 30; k++) begin
            din_a = {(((k / 3) % 2) == 0), 1'b1};
            step();
            r1 += int'(rise_a[1]);
            f1 += int'(fall_a[1]);
            p0 += int'(rise_a[0] | fall_a[0]);
        end
        chk("bounce_no_early", r1, 0);
        for (int n = 1; n <= 20; n++) begin
            din_a = 2'b11;
            step();
            if (rise_a[1]) begin
                r1++;
                if (rn == 0) rn = n;
            end
            f1 += int'(fall_a[1]);
            p0 += int'(rise_a[0] | fall_a[0]);
        end
        chk("bounce_rise_cnt", r1, 1);
        chk("bounce_fall_cnt", f1, 0);
        chk("bounce_rise_lat", rn, 13);
        chk("bounce_ch0_quiet", p0, 0);
        chk("bounce_dout", dout_a, 2'b11);

        // both channels fall together
        nf = 0;
        for (int n = 1; n <= 20; n++) begin
            din_a = 2'b00;
            step();
            if (dout_a !== 2'b11) begin
                nf = n;
                break;
            end
        end
        chk("fall_lat_ok", int'(nf >= 11 && nf <= 15), 1);
        chk("fall_dout", dout_a, 2'b00);
        chk("fall_pulse", fall_a, 2'b11);
        chk("fall_norise", rise_a, 2'b00);
        step();
        chk("fall_one_cycle", fall_a, 2'b00);

        // reset asserted while the rise pulse is high
        got = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            din_a = 2'b11;
            step();
            if (rise_a == 2'b11) begin
                got = 1'b1;
                break;
            end
        end
        chk("rise_both_seen", got, 1);
        rst_a = 1'b0;
        #1;
        chk("async_rst_dout", dout_a, 2'b00);
        chk("async_rst_rise", rise_a, 2'b00);
        chk("async_rst_tick", tick_a, 0);
        @(negedge clk);
        rst_a = 1'b1;
        din_a = 2'b00;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk($sformatf("rel_tick%0d", n), tick_a, int'((n % 4) == 0));
            chk($sformatf("rel_dout%0d", n), dout_a, 2'b00);
            chk($sformatf("rel_pulse%0d", n), {rise_a, fall_a}, 0);
        end

        // pass-through instance: dout is din delayed by 3 cycles
        rst_b = 1'b1;
        prev_d = 2'b11;
        for (int i = 0; i < 15; i++) begin
            din_b = pat[i];
            step();
            exp_d = (i >= 2) ? pat[i-2] : 2'b11;
            chk($sformatf("pt%0d_dout", i), dout_b, exp_d);
            chk($sformatf("pt%0d_rise", i), rise_b, exp_d & ~prev_d);
            chk($sformatf("pt%0d_fall", i), fall_b, ~exp_d & prev_d);
            chk($sformatf("pt%0d_tick", i), tick_b, 1);
            prev_d = exp_d;
        end

        // reset while a change is still in the synchroniser
        din_b = 2'b11;
        step();
        rst_b = 1'b0;
        #1;
        chk("b_rst_dout", dout_b, 2'b11);
        chk("b_rst_pulse", {rise_b, fall_b}, 0);
        @(negedge clk);
        rst_b = 1'b1;
        p0 = 0;
        for (int n = 1; n <= 6; n++) begin
            step();
            p0 += int'(|{rise_b, fall_b});
            chk($sformatf("b_rel_dout%0d", n), dout_b, 2'b11);
        end
        chk("b_rel_no_pulse", p0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel input debouncer for mechanical switches, buttons and rotary-encoder contacts. Each channel is synchronised into the clock domain, sampled on a shared divided-down tick, and passed to the output only after it holds a new level for a programmable number of consecutive ticks. The block also emits one-cycle rise and fall pulses per channel. It sits between board pins and the encoder decoder and control logic.

## Interface
- CHANNELS, 2: number of independent input channels (≥1).
- CLK_DIV, 100: clk cycles per sample tick (≥1); 100 gives 1 µs at 100 MHz.
- STABLE_COUNT, 4: consecutive ticks a new level must persist before dout changes (≥1).
- INIT, 0: reset level of every dout bit and of the synchroniser flops (0 or 1).

- clk  in  1  system clock; all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  CHANNELS  raw asynchronous inputs.
- dout  out  CHANNELS  debounced levels.
- rise  out  CHANNELS  one-cycle pulse when dout[i] goes 0→1.
- fall  out  CHANNELS  one-cycle pulse when dout[i] goes 1→0.
- tick  out  1  sample strobe, high for one cycle every CLK_DIV cycles (for debug/observation).

## Operation
- Synchroniser: two flops per channel (s1, s2), reset to INIT; s2 is the only value the filter sees.
- Divider: counter div of width clog2(CLK_DIV) (min 1), resets to 0, counts 0..CLK_DIV-1 and wraps. tick = (div == CLK_DIV-1), registered so tick is a clean flop output. CLK_DIV=1: tick high every cycle after reset.
- Per-channel filter, evaluated only when tick is high. The counter cnt has width clog2(STABLE_COUNT) (min 1) and resets to 0.
  - If s2 == dout: cnt ← 0. The level is stable and any partial count is discarded.
  - Else if cnt == STABLE_COUNT-1: dout ← s2, cnt ← 0. Assert rise if s2=1, fall if s2=0.
  - Else: cnt ← cnt+1.
- When tick is low, cnt and dout hold, and rise and fall are 0.
- rise and fall are registered and coincide with the cycle dout first shows the new value. They are never both high on one channel.
- Channels are fully independent. Simultaneous transitions on several channels update in the same cycle.
- A glitch that reverts before STABLE_COUNT ticks returns cnt to 0 and never reaches dout.

## Timing
- Reset values:
  - dout = INIT on all bits.
  - rise = 0, fall = 0, tick = 0.
  - div = 0, cnt = 0, synchroniser = INIT.
- Reset asserted mid-count or mid-pulse forces the reset values immediately, asynchronously. After rst_n deasserts, the first tick occurs CLK_DIV cycles later.
- Latency from a clean din step to dout/pulse:
  - 2 cycles of synchronisation.
  - Then up to CLK_DIV cycles to the first tick.
  - Then (STABLE_COUNT-1)·CLK_DIV cycles.
  - Then 1 registered cycle.
  - Worst case is 2 + STABLE_COUNT·CLK_DIV + 1 cycles; best case is 3 + (STABLE_COUNT-1)·CLK_DIV.
- Minimum stable pulse width passed is STABLE_COUNT·CLK_DIV cycles. Pulses shorter than (STABLE_COUNT-1)·CLK_DIV cycles are always rejected.
- STABLE_COUNT=1: dout follows s2 at every tick.

## Structure
- The package debounce_pkg holds the clog2-with-minimum-1 width function used for div and cnt. No typedefs are needed.
- The sub-module debounce_channel holds one synchroniser and filter (s1, s2, cnt, dout, rise, fall). Its inputs are din bit, tick, clk and rst_n.
- debounce_bank holds the shared divider and a generate loop over CHANNELS instances of debounce_channel.

## Test plan
- Reset, with CHANNELS=2, CLK_DIV=4, STABLE_COUNT=3, INIT=0: hold rst_n=0 and drive din=2'b11.
  - During reset: dout=00 and rise=fall=0.
  - After release: tick first high on cycle 4, then every 4 cycles.
- Clean step: din[0] 0→1 and hold, same parameters.
  - dout[0]=1 on the third tick seeing s2=1, plus 1 cycle; rise[0]=1 for exactly that cycle.
  - dout[1] stays 0.
- Glitch rejection: din[0] high for 6 cycles, then low.
  - dout[0] never changes and rise[0] never pulses.
  - cnt returns to 0 at the next tick.
- Bounce then settle: din[1] toggles every 3 cycles for 30 cycles, then holds 1.
  - Exactly one rise[1] pulse, and no fall[1] pulse.
  - It arrives 3 ticks (plus sync and register latency) after din settles.
- Falling edge and simultaneity: both channels at 1 drop to 0 on the same cycle.
  - dout goes 11→00 in a single cycle, with fall=11 for one cycle.
- Reset mid-count and INIT=1, STABLE_COUNT=1, CLK_DIV=1:
  - With reset mid-count, dout=INIT immediately and no pulse appears after release.
  - dout tracks din with 3-cycle delay, and rise/fall pulse on every edge.
